// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module  : multicycle_control
// Brief   : Multicycle RV32I control FSM driving the shared ALU/memory datapath.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control #(
    parameter int SUPPORT_IALU   = 1,
    parameter int SUPPORT_BRANCH = 1,
    parameter int SUPPORT_JAL    = 1,
    parameter int MEM_WAIT       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op_code,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_source,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_type,
    output logic [2:0] alu_control,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_IALU  = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_SLT  = 3'b101;
    localparam logic [2:0] c_ALU_NONE = 3'b111;

    state_t r_state;
    state_t w_next;

    logic w_ready;
    logic w_is_load, w_is_store, w_is_rtype, w_is_ialu, w_is_br, w_is_jal;
    logic w_alu_f3_ok, w_rtype_ok, w_br_ok, w_mem_ok;
    logic [2:0] w_alu_func;

    // With wait states disabled every memory access completes in one cycle.
    assign w_ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;

    assign w_is_load  = (op_code == c_OP_LOAD);
    assign w_is_store = (op_code == c_OP_STORE);
    assign w_is_rtype = (op_code == c_OP_RTYPE);
    assign w_is_ialu  = (op_code == c_OP_IALU) && (SUPPORT_IALU != 0);
    assign w_is_br    = (op_code == c_OP_BR)   && (SUPPORT_BRANCH != 0);
    assign w_is_jal   = (op_code == c_OP_JAL)  && (SUPPORT_JAL != 0);

    assign w_alu_f3_ok = (func3 == 3'b000) || (func3 == 3'b010) ||
                         (func3 == 3'b110) || (func3 == 3'b111);
    assign w_rtype_ok  = w_alu_f3_ok &&
                         ((func7 == 7'b0000000) ||
                          ((func7 == 7'b0100000) && (func3 == 3'b000)));
    assign w_br_ok     = (func3 == 3'b000) || (func3 == 3'b001);
    assign w_mem_ok    = (func3 == 3'b010);

    always_comb begin
        w_alu_func = c_ALU_NONE;
        case (func3)
            3'b000:  w_alu_func = ((r_state == S_EXECR) && func7[5]) ? c_ALU_SUB : c_ALU_ADD;
            3'b010:  w_alu_func = c_ALU_SLT;
            3'b110:  w_alu_func = c_ALU_OR;
            3'b111:  w_alu_func = c_ALU_AND;
            default: w_alu_func = c_ALU_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:  w_next = S_FETCH;
            S_FETCH:  w_next = w_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if ((w_is_load || w_is_store) && w_mem_ok) w_next = S_MEMADR;
                else if (w_is_rtype && w_rtype_ok)         w_next = S_EXECR;
                else if (w_is_ialu && w_alu_f3_ok)         w_next = S_EXECI;
                else if (w_is_br && w_br_ok)               w_next = S_BRANCH;
                else if (w_is_jal)                         w_next = S_JAL;
                else                                       w_next = S_TRAP;
            end
            S_MEMADR:   w_next = w_is_store ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = w_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = w_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    w_next = S_ALUWB;
            S_EXECI:    w_next = S_ALUWB;
            S_ALUWB:    w_next = S_FETCH;
            S_BRANCH:   w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_TRAP:     w_next = S_TRAP;
            default:    w_next = S_TRAP;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        adr_source    = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_source = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        imm_type      = c_IMM_I;
        alu_control   = c_ALU_NONE;
        illegal       = 1'b0;
        case (r_state)
            S_RESET: alu_control = c_ALU_ADD;
            S_FETCH: begin
                alu_src_b     = 2'b10;
                alu_control   = c_ALU_ADD;
                result_source = 2'b10;
                ir_write      = w_ready;
                pc_write      = w_ready;
            end
            S_DECODE: begin
                // Computes the branch/jump target into the ALU-out register.
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                alu_control = c_ALU_ADD;
                if (op_code == c_OP_STORE)    imm_type = c_IMM_S;
                else if (op_code == c_OP_BR)  imm_type = c_IMM_B;
                else if (op_code == c_OP_JAL) imm_type = c_IMM_J;
                else                          imm_type = c_IMM_I;
            end
            S_MEMADR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = c_ALU_ADD;
                imm_type    = w_is_store ? c_IMM_S : c_IMM_I;
            end
            S_MEMREAD: adr_source = 1'b1;
            S_MEMWB: begin
                result_source = 2'b01;
                reg_write     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_source = 1'b1;
                mem_write  = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = w_alu_func;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_alu_func;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = c_ALU_SUB;
                pc_write    = (func3 == 3'b001) ? ~zero : zero;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                alu_control = c_ALU_ADD;
                pc_write    = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

    assign state = r_state;

endmodule

`default_nettype wire
